// File: rtl/cpu_pkg.sv
// Shared defaults, log2 helper and occupancy-state encoding for the
// write-back destination queue.
package cpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  // Ceiling log2, usable in constant expressions (port widths, localparams).
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array plus read/write pointers for the destination queue.
// Occupancy tracking is left to the instantiating block.
module sync_fifo_mem
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF + 2,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  localparam int PW = clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // DEPTH is a power of two, so the natural binary wrap gives DEPTH-1 -> 0.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];

endmodule

// File: rtl/dest_select_queue.sv
// Queue of {destination select, write data} requests feeding the 2-to-4
// write-back decoder; head entry drives dec_en/dec_addr/wr_data directly.
//
//   state       | meaning
//   ------------+--------------------------------------------
//   OCC_EMPTY   | count == 0, decoder disabled
//   OCC_PARTIAL | 0 < count < DEPTH, accepting and presenting
//   OCC_FULL    | count == DEPTH, in_ready low
module dest_select_queue
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_addr,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 out_stall,
  output logic                 dec_en,
  output logic [1:0]           dec_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic [clog2(DEPTH):0] count
);

  localparam int CW = clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  occ_state_e        state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop;
  logic [DATA_W+1:0] head;

  // Handshakes look only at registered state, never at same-cycle inputs.
  assign in_ready = (state_q != OCC_FULL);
  assign dec_en   = (state_q != OCC_EMPTY);
  assign push     = in_valid & in_ready;
  assign pop      = dec_en & ~out_stall;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    case (state_q)
      OCC_EMPTY: begin
        if (push) state_d = OCC_PARTIAL;
      end
      OCC_PARTIAL: begin
        if (push && !pop && count_q == FULL_CNT - CW'(1)) state_d = OCC_FULL;
        else if (pop && !push && count_q == CW'(1))      state_d = OCC_EMPTY;
      end
      OCC_FULL: begin
        if (pop) state_d = OCC_PARTIAL;
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OCC_EMPTY;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  sync_fifo_mem #(
    .WIDTH (DATA_W + 2),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({in_addr, in_data}),
    .rdata (head)
  );

  assign dec_addr = head[DATA_W+1:DATA_W];
  assign wr_data  = head[DATA_W-1:0];
  assign count    = count_q;

endmodule
